// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM encoding, fault codes and bus response codes.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_BUS      = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'd0;

  // Instructions are word aligned; any set low address bit is a fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Single-beat AXI-lite-style read bus (AR and R channels only).
// master = fetch unit, slave = instruction memory.
interface ifu_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid,
    input  arready,
    output araddr,
    input  rvalid,
    output rready,
    input  rdata,
    input  rresp
  );

  modport slave (
    input  arvalid,
    output arready,
    input  araddr,
    output rvalid,
    input  rready,
    output rdata,
    output rresp
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: takes a PC, performs one bus read at a time and
// hands the instruction, its PC and a fault code to decode.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,

  ifu_fetch_if.master       mem,

  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [1:0]        fault_o,
  output logic [31:0]       fetch_cnt_o
);

  state_t            state_reg,   state_next;
  logic              kill_reg,    kill_next;
  logic [ADDR_W-1:0] araddr_reg,  araddr_next;
  logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
  logic [DATA_W-1:0] inst_reg,    inst_next;
  logic [1:0]        fault_reg,   fault_next;
  logic [31:0]       cnt_reg,     cnt_next;

  logic accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      kill_reg    <= 1'b0;
      araddr_reg  <= '0;
      inst_pc_reg <= '0;
      inst_reg    <= '0;
      fault_reg   <= FLT_NONE;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      kill_reg    <= kill_next;
      araddr_reg  <= araddr_next;
      inst_pc_reg <= inst_pc_next;
      inst_reg    <= inst_next;
      fault_reg   <= fault_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    kill_next    = kill_reg;
    araddr_next  = araddr_reg;
    inst_pc_next = inst_pc_reg;
    inst_next    = inst_reg;
    fault_next   = fault_reg;
    cnt_next     = cnt_reg;

    pc_ready_o = (state_reg == ST_IDLE) && !flush_i;
    accept     = pc_valid_i && pc_ready_o;

    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          araddr_next  = pc_i;
          inst_pc_next = pc_i;
          if (is_misaligned(pc_i[1:0])) begin
            inst_next  = '0;
            fault_next = FLT_MISALIGN;
            state_next = ST_OUT;
          end else begin
            state_next = ST_ADDR;
          end
        end
      end

      // The address phase always completes, even when flushed; the result
      // is dropped later via kill.
      ST_ADDR: begin
        if (flush_i) kill_next = 1'b1;
        if (mem.arready) state_next = ST_DATA;
      end

      ST_DATA: begin
        if (mem.rvalid) begin
          if (!kill_reg && !flush_i) begin
            inst_next  = mem.rdata;
            fault_next = (mem.rresp != RESP_OKAY) ? FLT_BUS : FLT_NONE;
            state_next = ST_OUT;
          end else begin
            kill_next  = 1'b0;
            state_next = ST_IDLE;
          end
        end else if (flush_i) begin
          kill_next = 1'b1;
        end
      end

      // Flush wins over a simultaneous decode handshake.
      ST_OUT: begin
        if (flush_i) begin
          state_next = ST_IDLE;
        end else if (inst_ready_i) begin
          cnt_next   = cnt_reg + 32'd1;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign mem.arvalid  = (state_reg == ST_ADDR);
  assign mem.araddr   = araddr_reg;
  assign mem.rready   = (state_reg == ST_DATA);

  assign inst_valid_o = (state_reg == ST_OUT);
  assign inst_o       = inst_reg;
  assign inst_pc_o    = inst_pc_reg;
  assign fault_o      = fault_reg;
  assign fetch_cnt_o  = cnt_reg;

  rvalid_only_in_data: assert property (
    @(posedge clk) disable iff (rst) mem.rvalid |-> (state_reg == ST_DATA)
  );

endmodule
